// File: rtl/multicycle_control.sv
// multicycle_control
//   Moore control unit for the multicycle MIPS datapath. It produces every
//   datapath control wire from the registered state. Supported instructions
//   are add/sub/and (R-type), addi, lw, sw, beq and j.
//
//   Parameter MEM_WAIT (1..7): cycles spent in each memory-read wait state
//   (instruction fetch and lw) before the read data is captured.
//
//   Ports
//     clk, reset          clock, synchronous active-high reset
//     opcode, funct       IR[31:26], IR[5:0]
//     zero, overflow      ula32 flags
//     PC_wr .. PC_src     datapath register loads, strobes and mux selects
//     illegal_op          one-cycle pulse in DECODE on an unsupported instruction
//     ovf_exc             one-cycle pulse when an overflow cancels writeback
//     state_dbg           current state encoding
//
// state       | meaning
// ------------+-----------------------------------------------------------
// RESET       | post-reset idle, all outputs low
// FETCH       | instruction read issued from PC, wait counter loaded
// FETCH_WAIT  | memory wait; last cycle loads IR and PC <= PC+4
// DECODE      | register read into A/B, branch target into ALUOut
// EXEC_R      | R-type ALU operation into ALUOut
// WB_R        | write ALUOut to rd
// EXEC_ADDI   | A + imm into ALUOut
// WB_I        | write ALUOut to rt
// OVF         | overflow: writeback suppressed, ovf_exc pulse
// ADDR        | A + imm effective address into ALUOut
// MEM_RD      | data read issued from ALUOut, wait counter loaded
// MEM_WAIT_ST | memory wait; last cycle loads MDR
// WB_LW       | write MDR to rt
// MEM_WR      | store B at ALUOut
// BRANCH      | A - B compare; PC <= ALUOut when zero
// JUMP        | PC <= jump target
module multicycle_control #(
  parameter int unsigned MEM_WAIT = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       overflow,
  output logic       PC_wr,
  output logic       IorD,
  output logic       Mem_wr,
  output logic       IR_wr,
  output logic       MDR_wr,
  output logic       A_wr,
  output logic       B_wr,
  output logic       ALUOut_wr,
  output logic       Reg_wr,
  output logic       Reg_dst,
  output logic       Mem_to_reg,
  output logic       ALU_src_A,
  output logic [1:0] ALU_src_B,
  output logic [2:0] ALU_ctrl,
  output logic [1:0] PC_src,
  output logic       illegal_op,
  output logic       ovf_exc,
  output logic [3:0] state_dbg
);

  typedef enum logic [3:0] {
    S_RESET       = 4'd0,
    S_FETCH       = 4'd1,
    S_FETCH_WAIT  = 4'd2,
    S_DECODE      = 4'd3,
    S_EXEC_R      = 4'd4,
    S_WB_R        = 4'd5,
    S_EXEC_ADDI   = 4'd6,
    S_WB_I        = 4'd7,
    S_OVF         = 4'd8,
    S_ADDR        = 4'd9,
    S_MEM_RD      = 4'd10,
    S_MEM_WAIT_ST = 4'd11,
    S_WB_LW       = 4'd12,
    S_MEM_WR      = 4'd13,
    S_BRANCH      = 4'd14,
    S_JUMP        = 4'd15
  } state_e;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_J    = 6'h02;

  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_AND  = 6'h24;

  localparam logic [2:0] ALU_ADD = 3'b001;
  localparam logic [2:0] ALU_SUB = 3'b010;
  localparam logic [2:0] ALU_AND = 3'b011;

  // Wait counter counts down to zero; the state leaves on the zero cycle, so
  // loading MEM_WAIT-1 yields exactly MEM_WAIT wait cycles.
  localparam logic [2:0] WAIT_LOAD = 3'(MEM_WAIT - 1);

  state_e     state_q, state_d;
  logic [2:0] wait_cnt_q, wait_cnt_d;
  logic       funct_legal;
  logic       funct_arith;
  logic [2:0] alu_r_ctrl;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_RESET;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  always_comb begin
    funct_arith = (funct == FN_ADD) || (funct == FN_SUB);
    funct_legal = funct_arith || (funct == FN_AND);
    case (funct)
      FN_ADD:  alu_r_ctrl = ALU_ADD;
      FN_SUB:  alu_r_ctrl = ALU_SUB;
      FN_AND:  alu_r_ctrl = ALU_AND;
      default: alu_r_ctrl = 3'b000;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    PC_wr      = 1'b0;
    IorD       = 1'b0;
    Mem_wr     = 1'b0;
    IR_wr      = 1'b0;
    MDR_wr     = 1'b0;
    A_wr       = 1'b0;
    B_wr       = 1'b0;
    ALUOut_wr  = 1'b0;
    Reg_wr     = 1'b0;
    Reg_dst    = 1'b0;
    Mem_to_reg = 1'b0;
    ALU_src_A  = 1'b0;
    ALU_src_B  = 2'b00;
    ALU_ctrl   = 3'b000;
    PC_src     = 2'b00;
    illegal_op = 1'b0;
    ovf_exc    = 1'b0;

    case (state_q)
      S_RESET: begin
        state_d = S_FETCH;
      end
      S_FETCH: begin
        wait_cnt_d = WAIT_LOAD;
        state_d    = S_FETCH_WAIT;
      end
      S_FETCH_WAIT: begin
        if (wait_cnt_q != 3'd0) begin
          wait_cnt_d = wait_cnt_q - 3'd1;
        end else begin
          IR_wr     = 1'b1;
          PC_wr     = 1'b1;
          ALU_src_B = 2'b01;
          ALU_ctrl  = ALU_ADD;
          state_d   = S_DECODE;
        end
      end
      S_DECODE: begin
        A_wr      = 1'b1;
        B_wr      = 1'b1;
        ALUOut_wr = 1'b1;
        ALU_src_B = 2'b11;
        ALU_ctrl  = ALU_ADD;
        if (opcode == OP_R && funct_legal) begin
          state_d = S_EXEC_R;
        end else if (opcode == OP_ADDI) begin
          state_d = S_EXEC_ADDI;
        end else if (opcode == OP_LW || opcode == OP_SW) begin
          state_d = S_ADDR;
        end else if (opcode == OP_BEQ) begin
          state_d = S_BRANCH;
        end else if (opcode == OP_J) begin
          state_d = S_JUMP;
        end else begin
          illegal_op = 1'b1;
          state_d    = S_FETCH;
        end
      end
      S_EXEC_R: begin
        ALU_src_A = 1'b1;
        ALU_ctrl  = alu_r_ctrl;
        ALUOut_wr = 1'b1;
        // and cannot overflow; the flag is ignored for it
        state_d   = (overflow && funct_arith) ? S_OVF : S_WB_R;
      end
      S_WB_R: begin
        Reg_wr  = 1'b1;
        Reg_dst = 1'b1;
        state_d = S_FETCH;
      end
      S_EXEC_ADDI: begin
        ALU_src_A = 1'b1;
        ALU_src_B = 2'b10;
        ALU_ctrl  = ALU_ADD;
        ALUOut_wr = 1'b1;
        state_d   = overflow ? S_OVF : S_WB_I;
      end
      S_WB_I: begin
        Reg_wr  = 1'b1;
        state_d = S_FETCH;
      end
      S_OVF: begin
        ovf_exc = 1'b1;
        state_d = S_FETCH;
      end
      S_ADDR: begin
        ALU_src_A = 1'b1;
        ALU_src_B = 2'b10;
        ALU_ctrl  = ALU_ADD;
        ALUOut_wr = 1'b1;
        if (opcode == OP_LW) begin
          state_d = S_MEM_RD;
        end else if (opcode == OP_SW) begin
          state_d = S_MEM_WR;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_MEM_RD: begin
        IorD       = 1'b1;
        wait_cnt_d = WAIT_LOAD;
        state_d    = S_MEM_WAIT_ST;
      end
      S_MEM_WAIT_ST: begin
        if (wait_cnt_q != 3'd0) begin
          wait_cnt_d = wait_cnt_q - 3'd1;
        end else begin
          MDR_wr  = 1'b1;
          state_d = S_WB_LW;
        end
      end
      S_WB_LW: begin
        Reg_wr     = 1'b1;
        Mem_to_reg = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEM_WR: begin
        IorD    = 1'b1;
        Mem_wr  = 1'b1;
        state_d = S_FETCH;
      end
      S_BRANCH: begin
        ALU_src_A = 1'b1;
        ALU_ctrl  = ALU_SUB;
        PC_src    = 2'b01;
        PC_wr     = zero;
        state_d   = S_FETCH;
      end
      S_JUMP: begin
        PC_src  = 2'b10;
        PC_wr   = 1'b1;
        state_d = S_FETCH;
      end
      default: begin
        state_d = S_RESET;
      end
    endcase
  end

  assign state_dbg = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control. Two instances (MEM_WAIT=1 and MEM_WAIT=3)
// share the same stimulus. For every instruction the bench derives the
// expected cycle-by-cycle schedule (state plus all outputs) from the
// instruction class and the memory latency, then compares both DUTs against
// it at each falling edge.
module tb_multicycle_control;

  logic       clk;
  logic       reset;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       overflow;

  logic       PC_wr_w [2];
  logic       IorD_w [2];
  logic       Mem_wr_w [2];
  logic       IR_wr_w [2];
  logic       MDR_wr_w [2];
  logic       A_wr_w [2];
  logic       B_wr_w [2];
  logic       ALUOut_wr_w [2];
  logic       Reg_wr_w [2];
  logic       Reg_dst_w [2];
  logic       Mem_to_reg_w [2];
  logic       ALU_src_A_w [2];
  logic [1:0] ALU_src_B_w [2];
  logic [2:0] ALU_ctrl_w [2];
  logic [1:0] PC_src_w [2];
  logic       illegal_op_w [2];
  logic       ovf_exc_w [2];
  logic [3:0] state_dbg_w [2];
  logic [24:0] act [2];

  for (genvar k = 0; k < 2; k++) begin : g_dut
    multicycle_control #(.MEM_WAIT(k == 0 ? 1 : 3)) u_dut (
      .clk        (clk),
      .reset      (reset),
      .opcode     (opcode),
      .funct      (funct),
      .zero       (zero),
      .overflow   (overflow),
      .PC_wr      (PC_wr_w[k]),
      .IorD       (IorD_w[k]),
      .Mem_wr     (Mem_wr_w[k]),
      .IR_wr      (IR_wr_w[k]),
      .MDR_wr     (MDR_wr_w[k]),
      .A_wr       (A_wr_w[k]),
      .B_wr       (B_wr_w[k]),
      .ALUOut_wr  (ALUOut_wr_w[k]),
      .Reg_wr     (Reg_wr_w[k]),
      .Reg_dst    (Reg_dst_w[k]),
      .Mem_to_reg (Mem_to_reg_w[k]),
      .ALU_src_A  (ALU_src_A_w[k]),
      .ALU_src_B  (ALU_src_B_w[k]),
      .ALU_ctrl   (ALU_ctrl_w[k]),
      .PC_src     (PC_src_w[k]),
      .illegal_op (illegal_op_w[k]),
      .ovf_exc    (ovf_exc_w[k]),
      .state_dbg  (state_dbg_w[k])
    );
    assign act[k] = {state_dbg_w[k], PC_wr_w[k], IorD_w[k], Mem_wr_w[k], IR_wr_w[k],
                     MDR_wr_w[k], A_wr_w[k], B_wr_w[k], ALUOut_wr_w[k], Reg_wr_w[k],
                     Reg_dst_w[k], Mem_to_reg_w[k], ALU_src_A_w[k], ALU_src_B_w[k],
                     ALU_ctrl_w[k], PC_src_w[k], illegal_op_w[k], ovf_exc_w[k]};
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // state codes in declaration order
  localparam logic [3:0] ST_RESET = 4'd0,  ST_FETCH = 4'd1,  ST_FW = 4'd2,    ST_DEC = 4'd3;
  localparam logic [3:0] ST_EXR   = 4'd4,  ST_WBR   = 4'd5,  ST_EXI = 4'd6,   ST_WBI = 4'd7;
  localparam logic [3:0] ST_OVF   = 4'd8,  ST_ADDR  = 4'd9,  ST_MRD = 4'd10,  ST_MWS = 4'd11;
  localparam logic [3:0] ST_WBLW  = 4'd12, ST_MWR   = 4'd13, ST_BR  = 4'd14,  ST_J   = 4'd15;

  // output bit masks: {PC_wr,IorD,Mem_wr,IR_wr,MDR_wr,A_wr,B_wr,ALUOut_wr,Reg_wr,
  //                    Reg_dst,Mem_to_reg,ALU_src_A,ALU_src_B,ALU_ctrl,PC_src,illegal,ovf}
  localparam logic [20:0] PCW  = 21'h100000, IORD = 21'h080000, MEMW = 21'h040000;
  localparam logic [20:0] IRW  = 21'h020000, MDRW = 21'h010000, AW   = 21'h008000;
  localparam logic [20:0] BW   = 21'h004000, AOW  = 21'h002000, REGW = 21'h001000;
  localparam logic [20:0] RDST = 21'h000800, M2R  = 21'h000400, SRCA = 21'h000200;
  localparam logic [20:0] SB_4 = 21'h000080, SB_I = 21'h000100, SB_BR = 21'h000180;
  localparam logic [20:0] ADD  = 21'h000010, SUB  = 21'h000020, ANDC = 21'h000030;
  localparam logic [20:0] PS_AO = 21'h000004, PS_J = 21'h000008;
  localparam logic [20:0] ILL  = 21'h000002, OVFB = 21'h000001;
  localparam logic [20:0] NONE = 21'h000000;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  string cur_name = "init";
  logic [24:0] q0[$];
  logic [24:0] q1[$];
  logic [24:0] tmp[$];
  int c_irw[2], c_pcw[2], c_regw[2], c_ovf[2], c_ill[2], c_memw[2];

  function automatic logic [24:0] ent(input logic [3:0] st, input logic [20:0] o);
    return {st, o};
  endfunction

  // Expected schedule for one instruction, from its FETCH up to and
  // including the next FETCH.
  task automatic build(input int mw, input logic [5:0] op, input logic [5:0] fn,
                       input logic z, input logic ov);
    logic        r_ok;
    logic [20:0] dec;
    logic [20:0] rc;
    r_ok = (op == 6'h00) && (fn == 6'h20 || fn == 6'h22 || fn == 6'h24);
    rc   = (fn == 6'h20) ? ADD : (fn == 6'h22) ? SUB : ANDC;
    dec  = AW | BW | AOW | SB_BR | ADD;
    tmp.delete();
    tmp.push_back(ent(ST_FETCH, NONE));
    for (int i = 0; i < mw - 1; i++) tmp.push_back(ent(ST_FW, NONE));
    tmp.push_back(ent(ST_FW, PCW | IRW | SB_4 | ADD));
    if (r_ok) begin
      tmp.push_back(ent(ST_DEC, dec));
      tmp.push_back(ent(ST_EXR, SRCA | AOW | rc));
      if (ov && fn != 6'h24) tmp.push_back(ent(ST_OVF, OVFB));
      else                   tmp.push_back(ent(ST_WBR, REGW | RDST));
    end else if (op == 6'h08) begin
      tmp.push_back(ent(ST_DEC, dec));
      tmp.push_back(ent(ST_EXI, SRCA | SB_I | ADD | AOW));
      if (ov) tmp.push_back(ent(ST_OVF, OVFB));
      else    tmp.push_back(ent(ST_WBI, REGW));
    end else if (op == 6'h23 || op == 6'h2B) begin
      tmp.push_back(ent(ST_DEC, dec));
      tmp.push_back(ent(ST_ADDR, SRCA | SB_I | ADD | AOW));
      if (op == 6'h23) begin
        tmp.push_back(ent(ST_MRD, IORD));
        for (int i = 0; i < mw - 1; i++) tmp.push_back(ent(ST_MWS, NONE));
        tmp.push_back(ent(ST_MWS, MDRW));
        tmp.push_back(ent(ST_WBLW, REGW | M2R));
      end else begin
        tmp.push_back(ent(ST_MWR, IORD | MEMW));
      end
    end else if (op == 6'h04) begin
      tmp.push_back(ent(ST_DEC, dec));
      tmp.push_back(ent(ST_BR, SRCA | SUB | PS_AO | (z ? PCW : NONE)));
    end else if (op == 6'h02) begin
      tmp.push_back(ent(ST_DEC, dec));
      tmp.push_back(ent(ST_J, PS_J | PCW));
    end else begin
      tmp.push_back(ent(ST_DEC, dec | ILL));
    end
    tmp.push_back(ent(ST_FETCH, NONE));
  endtask

  task automatic chk_vec(input int k, input logic [24:0] got, input logic [24:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s mw=%0d cyc=%0d: got state=%0d out=%h, want state=%0d out=%h",
               cur_name, (k == 0) ? 1 : 3, cyc, got[24:21], got[20:0], want[24:21], want[20:0]);
    end
  endtask

  task automatic chk_int(input string name, input int got, input int want);
    n_cmp++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  // One cycle: sample both DUTs at the falling edge against the schedule.
  task automatic step();
    logic [24:0] e;
    @(negedge clk);
    cyc++;
    for (int k = 0; k < 2; k++) begin
      if ((k == 0 && q0.size() > 0) || (k == 1 && q1.size() > 0)) begin
        e = (k == 0) ? q0.pop_front() : q1.pop_front();
        chk_vec(k, act[k], e);
        c_irw[k]  += int'(IR_wr_w[k]);
        c_pcw[k]  += int'(PC_wr_w[k]);
        c_regw[k] += int'(Reg_wr_w[k]);
        c_ovf[k]  += int'(ovf_exc_w[k]);
        c_ill[k]  += int'(illegal_op_w[k]);
        c_memw[k] += int'(Mem_wr_w[k]);
      end
    end
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    for (int i = 0; i < n; i++) begin
      q0.push_back(ent(ST_RESET, NONE));
      q1.push_back(ent(ST_RESET, NONE));
    end
    for (int i = 0; i < n; i++) step();
    reset = 1'b0;
  endtask

  task automatic run(input string name, input logic [5:0] op, input logic [5:0] fn,
                     input logic z, input logic ov, input int nrst, input int trunc1);
    int guard;
    cur_name = name;
    for (int k = 0; k < 2; k++) begin
      c_irw[k] = 0; c_pcw[k] = 0; c_regw[k] = 0; c_ovf[k] = 0; c_ill[k] = 0; c_memw[k] = 0;
    end
    opcode = op; funct = fn; zero = z; overflow = ov;
    do_reset(nrst);
    build(1, op, fn, z, ov);
    q0 = tmp;
    build(3, op, fn, z, ov);
    q1 = tmp;
    if (trunc1 > 0) while (q1.size() > trunc1) void'(q1.pop_back());
    guard = 0;
    while ((q0.size() > 0 || q1.size() > 0) && guard < 200) begin
      step();
      guard++;
    end
    chk_int({name, "_done"}, q0.size() + q1.size(), 0);
  endtask

  initial begin
    reset = 1'b1; opcode = '0; funct = '0; zero = 1'b0; overflow = 1'b0;

    // model pins: FETCH-to-FETCH cycle counts
    build(1, 6'h00, 6'h20, 1'b0, 1'b0); chk_int("len_r",     tmp.size() - 1, 5);
    build(1, 6'h23, 6'h00, 1'b0, 1'b0); chk_int("len_lw",    tmp.size() - 1, 7);
    build(1, 6'h2B, 6'h00, 1'b0, 1'b0); chk_int("len_sw",    tmp.size() - 1, 5);
    build(1, 6'h04, 6'h00, 1'b1, 1'b0); chk_int("len_beq",   tmp.size() - 1, 4);
    build(1, 6'h02, 6'h00, 1'b0, 1'b0); chk_int("len_j",     tmp.size() - 1, 4);
    build(3, 6'h23, 6'h00, 1'b0, 1'b0); chk_int("len_lw_w3", tmp.size() - 1, 11);

    run("add", 6'h00, 6'h20, 1'b0, 1'b0, 3, 0);
    chk_int("add_irw_cnt", c_irw[0], 1);
    chk_int("add_pcw_cnt", c_pcw[0], 1);
    chk_int("add_regw_cnt", c_regw[0], 1);
    run("and", 6'h00, 6'h24, 1'b0, 1'b0, 1, 0);
    run("sub_ovf", 6'h00, 6'h22, 1'b0, 1'b1, 1, 0);
    chk_int("sub_ovf_cnt", c_ovf[0], 1);
    run("and_ovf_ignored", 6'h00, 6'h24, 1'b0, 1'b1, 2, 0);
    run("addi_ovf", 6'h08, 6'h11, 1'b0, 1'b1, 1, 0);
    chk_int("addi_ovf_cnt", c_ovf[1], 1);
    chk_int("addi_ovf_regw", c_regw[1], 0);
    run("addi", 6'h08, 6'h00, 1'b0, 1'b0, 1, 0);
    run("lw", 6'h23, 6'h00, 1'b0, 1'b0, 1, 0);
    run("sw", 6'h2B, 6'h00, 1'b0, 1'b0, 1, 0);
    chk_int("sw_memw_cnt", c_memw[1], 1);
    run("beq_taken", 6'h04, 6'h00, 1'b1, 1'b0, 1, 0);
    run("beq_not_taken", 6'h04, 6'h00, 1'b0, 1'b0, 1, 0);
    chk_int("beq_nt_pcw_cnt", c_pcw[0], 1);
    run("j", 6'h02, 6'h00, 1'b0, 1'b0, 1, 0);
    run("ill_op", 6'h3F, 6'h20, 1'b0, 1'b0, 1, 0);
    chk_int("ill_op_cnt", c_ill[0], 1);
    run("ill_funct", 6'h00, 6'h27, 1'b0, 1'b0, 1, 0);
    chk_int("ill_funct_cnt", c_ill[1], 1);
    chk_int("ill_funct_regw", c_regw[1], 0);
    // lw on the slow instance cut off in its second memory-wait cycle
    run("lw_abort", 6'h23, 6'h00, 1'b0, 1'b0, 1, 9);
    chk_int("lw_abort_regw", c_regw[1], 0);
    run("j_after_abort", 6'h02, 6'h00, 1'b0, 1'b0, 1, 0);
    chk_int("j_after_regw", c_regw[1], 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Moore-style FSM control unit for the multicycle MIPS CPU.
- Drives every control wire of the datapath: PC write, memory, IR, register file, ALU, muxes and pipeline registers.
- The datapath consumes these wires; this block is their producer.
- Receives opcode/funct from the instruction register and zero/overflow from ula32.
- Supported instructions: add, sub, and (R-type), addi, lw, sw, beq, j.

Parameters:
MEM_WAIT, 1, wait cycles inserted after every memory read (instruction fetch and lw) before data is consumed; legal range 1..7.

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
opcode  input  6  IR[31:26]
funct  input  6  IR[5:0]
zero  input  1  ula32 zero flag
overflow  input  1  ula32 overflow flag
PC_wr  output  1  PC register load
IorD  output  1  memory address: 0=PC, 1=ALUOut
Mem_wr  output  1  memory write strobe
IR_wr  output  1  instruction register load
MDR_wr  output  1  memory data register load
A_wr  output  1  A register load
B_wr  output  1  B register load
ALUOut_wr  output  1  ALUOut register load
Reg_wr  output  1  register bank write
Reg_dst  output  1  write address: 0=rt, 1=rd
Mem_to_reg  output  1  write data: 0=ALUOut, 1=MDR
ALU_src_A  output  1  0=PC, 1=A
ALU_src_B  output  2  00=B, 01=const 4, 10=sign-ext imm, 11=sign-ext imm<<2
ALU_ctrl  output  3  ula32 selector: 001 add, 010 sub, 011 and
PC_src  output  2  00=ALU result, 01=ALUOut, 10=jump target {PC[31:28],IR[25:0],00}
illegal_op  output  1  one-cycle pulse on an unsupported opcode/funct
ovf_exc  output  1  one-cycle pulse when an overflow suppresses writeback
state_dbg  output  4  current state encoding, for the bench

Behaviour:
- All state changes on rising clk. Reset is synchronous and takes priority over everything, including mid-instruction.
- Reset forces state RESET; all outputs are 0 while in RESET and wait_cnt clears.
- RESET lasts one cycle, then FETCH.
- Outputs decode from registered state only. Exception: PC_wr in BRANCH equals zero.
- Outputs not listed for a state are 0.
- Unused mux selects hold 0.
- Opcodes:
  - R=0x00
  - addi=0x08
  - lw=0x23
  - sw=0x2B
  - beq=0x04
  - j=0x02
- R-type funct codes:
  - add=0x20
  - sub=0x22
  - and=0x24

State sequence and outputs:
- FETCH: IorD=0.
  - Load wait_cnt=MEM_WAIT-1.
  - Next state FETCH_WAIT.
- FETCH_WAIT: hold while wait_cnt!=0, decrementing each cycle.
  - On the final cycle (wait_cnt==0): IR_wr=1, PC_wr=1, ALU_src_A=0, ALU_src_B=01, ALU_ctrl=001, PC_src=00, i.e. PC<=PC+4.
  - Next state DECODE.
- DECODE: A_wr=1, B_wr=1, ALUOut_wr=1, ALU_src_A=0, ALU_src_B=11, ALU_ctrl=001 (branch target precomputed).
  - Next state by opcode:
    - R with a legal funct → EXEC_R
    - addi → EXEC_ADDI
    - lw/sw → ADDR
    - beq → BRANCH
    - j → JUMP
  - Anything else: illegal_op=1 this cycle, next state FETCH.
- EXEC_R: ALU_src_A=1, ALU_src_B=00, ALU_ctrl from funct, ALUOut_wr=1.
  - If overflow=1 and funct is add/sub: next state OVF.
  - Otherwise next state WB_R.
- WB_R: Reg_wr=1, Reg_dst=1, Mem_to_reg=0. Next state FETCH.
- EXEC_ADDI: ALU_src_A=1, ALU_src_B=10, ALU_ctrl=001, ALUOut_wr=1.
  - If overflow=1: next state OVF.
  - Otherwise next state WB_I.
- WB_I: Reg_wr=1, Reg_dst=0, Mem_to_reg=0. Next state FETCH.
- OVF: ovf_exc=1; no register write. Next state FETCH.
- ADDR: ALU_src_A=1, ALU_src_B=10, ALU_ctrl=001, ALUOut_wr=1.
  - lw → MEM_RD; sw → MEM_WR.
- MEM_RD: IorD=1.
  - Load wait_cnt=MEM_WAIT-1.
  - Next state MEM_WAIT_ST.
- MEM_WAIT_ST: hold while wait_cnt!=0.
  - Final cycle: MDR_wr=1.
  - Next state WB_LW.
- WB_LW: Reg_wr=1, Reg_dst=0, Mem_to_reg=1. Next state FETCH.
- MEM_WR: IorD=1, Mem_wr=1. Next state FETCH.
- BRANCH: ALU_src_A=1, ALU_src_B=00, ALU_ctrl=010, PC_src=01, PC_wr=zero. Next state FETCH.
- JUMP: PC_src=10, PC_wr=1. Next state FETCH.

Cycle counts (reference points for verification):
- With MEM_WAIT=1, measured FETCH-to-next-FETCH:
  - R/addi: 5
  - lw: 7
  - sw: 5
  - beq: 4
  - j: 4
- Each increment of MEM_WAIT adds 1 cycle per memory read.

Test Plan:
- Reset asserted 3 cycles, then released → all outputs 0, state_dbg=RESET for one cycle, then FETCH. Reset asserted during MEM_WAIT_ST of a lw → next cycle is RESET, no Reg_wr ever asserted.
- opcode=0x00, funct=0x20, overflow=0 → exactly one IR_wr and one PC_wr in FETCH_WAIT; WB_R asserts Reg_wr=1, Reg_dst=1; next FETCH occurs 5 cycles after the first. Same with funct=0x24 → ALU_ctrl=011 in EXEC_R.
- opcode=0x08, overflow=1 in EXEC_ADDI → ovf_exc pulses once, Reg_wr stays 0, return to FETCH.
- opcode=0x23 with MEM_WAIT=3 → MEM_WAIT_ST lasts 3 cycles, MDR_wr only in the last, Reg_wr with Mem_to_reg=1; total 11 cycles. opcode=0x2B → single Mem_wr with IorD=1.
- opcode=0x04 with zero=1 → PC_wr=1, PC_src=01 in BRANCH; with zero=0 → PC_wr=0. opcode=0x02 → PC_wr=1, PC_src=10.
- opcode=0x3F, or opcode=0x00 with funct=0x27 → illegal_op pulses in DECODE, no writes, next state FETCH.
